prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of memory words; valid addresses are 0..DEPTH-1.
REQ-002 SHALL have parameter WIDTH, default 16, meaning the data and address width.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 SHALL have port base  input  WIDTH  first memory address of the load; sampled with start.
REQ-007 SHALL have port len  input  WIDTH  number of words to load; sampled with start.
REQ-008 SHALL have port abort  input  1  terminates a load in progress.
REQ-009 SHALL have port in_data  input  WIDTH  program word from the source.
REQ-010 SHALL have port in_valid  input  1  in_data is valid.
REQ-011 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-012 SHALL have port mem_addr  output  WIDTH  memory write address.
REQ-013 SHALL have port mem_data  output  WIDTH  memory write data.
REQ-014 SHALL have port mem_wren  output  1  memory write enable.
REQ-015 SHALL have port cpu_hold  output  1  holds the CPU in reset while high.
REQ-016 SHALL have port busy  output  1  a load is in progress.
REQ-017 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-018 SHALL have port err  output  1  sticky range-error flag.
REQ-019 SHALL have port checksum  output  WIDTH  modulo-2^WIDTH sum of the words written in the current or last load.

Function
REQ-020 SHALL implement the states IDLE, LOAD, FINISH, with all outputs registered.
REQ-021 SHALL leave IDLE only on start=1 and behave as follows:
- base+len > DEPTH (computed without WIDTH overflow): set err=1 and stay in IDLE.
- else if len=0: go to FINISH.
- else: go to LOAD, latch base and len, clear err and checksum, and zero the index.
REQ-022 SHALL, in LOAD, drive in_ready=1 and treat a word as accepted on a cycle where in_valid=1 and in_ready=1.
REQ-023 SHALL, for a word accepted at cycle N, drive mem_wren=1, mem_addr=base+index and mem_data=in_data at cycle N+1, add the word to checksum, and increment the index.
REQ-024 SHALL sustain one word per cycle while in_valid stays high, with no bubbles.
REQ-025 SHALL, on the cycle that accepts word len-1, drop in_ready and go to FINISH.
REQ-026 SHALL, in FINISH, pulse done=1 for one cycle and then return to IDLE.
REQ-027 SHALL keep mem_wren=0 in every cycle with no accepted word in the previous cycle.
REQ-028 SHALL, on abort=1 in LOAD, go to IDLE on the next edge without pulsing done.
- A word accepted in the same cycle as abort is still written.
- err and checksum keep their values.
REQ-029 SHALL ignore start outside IDLE and ignore abort outside LOAD.
REQ-030 SHALL drive busy=1 in LOAD and FINISH.
REQ-031 SHALL drive cpu_hold=1 from reset until the first done pulse, and re-assert it when a load starts.
REQ-032 SHALL never generate an address at or beyond base+len; the index counter saturates at len.

Reset
REQ-033 SHALL, while reset=1, force the following, with reset taking priority over every other input:
- state IDLE;
- in_ready=0, mem_wren=0, busy=0, done=0, err=0;
- mem_addr=0, mem_data=0, checksum=0, index=0;
- cpu_hold=1.
REQ-034 SHALL, when reset is asserted mid-load, drop all pending writes and issue no further mem_wren.

Verification
REQ-035 Basic load: start, base=0x0010, len=3, words 0x1111/0x2222/0x3333 on consecutive cycles -> writes to 0x10/0x11/0x12 on consecutive cycles, checksum=0x6666, done pulse, cpu_hold=0.
REQ-036 Backpressure gaps: len=4, in_valid toggled 1,0,1,0,... -> exactly 4 writes, each at accept+1 cycle, addresses contiguous.
REQ-037 Range error: base=0x03FE, len=3, DEPTH=1024 -> err=1, no mem_wren, state stays IDLE, cpu_hold unchanged.
REQ-038 Zero length: start with len=0 -> done pulse 1 cycle after FINISH entry, no writes, checksum=0.
REQ-039 Abort: len=8, abort after 2nd accepted word -> exactly 2 writes, no done, busy=0 next cycle, cpu_hold=1.
REQ-040 Reset mid-load: reset asserted after 1 of 5 words -> all outputs at REQ-033 values next edge, no further writes.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: streams words from a source into memory while holding the CPU.
// Range-checks the load window, keeps a running checksum, and supports abort.
module prog_loader #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] len,
  input  logic             abort,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_data,
  output logic             mem_wren,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [WIDTH:0]   DepthW = (WIDTH+1)'(DEPTH);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_data_q, mem_data_d;
  logic             mem_wren_q, mem_wren_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] csum_q, csum_d;

  logic [WIDTH:0]   end_sum;
  logic             accept;
  logic             last;

  // One extra bit so base+len cannot wrap past DEPTH.
  assign end_sum = {1'b0, base} + {1'b0, len};

  assign accept = (state_q == LOAD) && in_ready_q && in_valid
                  && (idx_q < len_q);
  assign last   = (idx_q == (len_q - One));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_wren_d = 1'b0;
    cpu_hold_d = cpu_hold_q;
    done_d     = 1'b0;
    err_d      = err_q;
    csum_d     = csum_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (end_sum > DepthW) begin
            err_d = 1'b1;
          end else begin
            err_d      = 1'b0;
            csum_d     = '0;
            idx_d      = '0;
            base_d     = base;
            len_d      = len;
            cpu_hold_d = 1'b1;
            state_d    = (len == '0) ? FINISH : LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          mem_wren_d = 1'b1;
          mem_addr_d = base_q + idx_q;
          mem_data_d = in_data;
          csum_d     = csum_q + in_data;
          idx_d      = idx_q + One;
        end
        if (abort) begin
          state_d = IDLE;
        end else if (accept && last) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wren_q <= 1'b0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wren_q <= mem_wren_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      csum_q     <= csum_d;
    end
  end

  assign in_ready = in_ready_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_wren = mem_wren_q;
  assign cpu_hold = cpu_hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign checksum = csum_q;

endmodule
